// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock divider / clock monitor pair: monitor state
// encoding and the default timing parameters both blocks agree on.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOST  = 2'd2
    } mon_state_e;

    localparam int DEF_CNT_W      = 20;
    localparam int DEF_EXP_PERIOD = 524288;
    localparam int DEF_TOL        = 64;
    localparam int DEF_TIMEOUT    = 600000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop that turns an asynchronous level into
// an immediate rise indication and registered single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise   = s2_q & ~s3_q;
        rise_d = s2_q & ~s3_q;
        fall_d = ~s2_q & s3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/clk_ctl_mon.sv
// Slow-clock monitor: converts clk_slow edges into clk-domain ticks, measures the
// rising-to-rising period, range-checks it and flags loss of clock.
module clk_ctl_mon
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_slow,
    output logic             tick,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             in_range,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);
    // Window bounds carry one extra bit so EXP_PERIOD+TOL never wraps.
    localparam logic [CNT_W:0]   WIN_LO  = (CNT_W+1)'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
    localparam logic [CNT_W:0]   WIN_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             in_range_q, in_range_d;
    logic [CNT_W-1:0] meas;
    logic             rise;
    logic             timeout;

    sync_edge u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .din        (clk_slow),
        .rise       (rise),
        .rise_pulse (tick),
        .fall_pulse (tick_fall)
    );

    always_comb begin
        meas         = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        timeout      = (cnt_q == CNT_TO);
        cnt_d        = rise ? '0 : meas;
        state_d      = state_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        in_range_d   = in_range_q;

        // A rise always beats a coincident timeout; intervals ending in IDLE or
        // LOST are not trusted, so only ARMED publishes a measurement.
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            ARMED: begin
                if (rise) begin
                    period_d     = meas;
                    period_vld_d = 1'b1;
                    in_range_d   = ({1'b0, meas} >= WIN_LO) && ({1'b0, meas} <= WIN_HI);
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (rise) begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            in_range_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            in_range_q   <= in_range_d;
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign in_range   = in_range_q;
    assign lost       = (state_q == LOST);

endmodule

// File: tb/tb_clk_ctl_mon.sv
// Scoreboard bench for clk_ctl_mon: an event-level model predicts every tick,
// fall, period update and lost change; a monitor matches what the DUT presents.
module tb_clk_ctl_mon;

    localparam int CNT_W      = 8;
    localparam int EXP_PERIOD = 16;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 40;
    localparam int LAT        = 3;
    localparam int HIST       = 16384;

    typedef struct packed {
        logic [31:0] cyc;
        logic        tick;
        logic        fall;
        logic        vld;
        logic [7:0]  period;
        logic        inr;
        logic        lost;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_slow = 1'b0;
    logic             tick;
    logic             tick_fall;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             in_range;
    logic             lost;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic lost_prev = 1'b0;
    ev_t  exp_q[$];
    logic hist_lost [0:HIST-1];

    // Model state: last reference point (tick or reset edge) and held outputs.
    int         m_ref = 0;
    logic       m_prev = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_lost = 1'b0;
    logic [7:0] m_period = 8'd0;
    logic       m_inr = 1'b0;

    clk_ctl_mon #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_slow   (clk_slow),
        .tick       (tick),
        .tick_fall  (tick_fall),
        .period     (period),
        .period_vld (period_vld),
        .in_range   (in_range),
        .lost       (lost)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < HIST; i++) hist_lost[i] = 1'b0;
    end

    // Drive one level per cycle; a level applied at cycle d shows up at d+3.
    task automatic applyStimulus(input logic lvl, input logic rst_v, input int n);
        ev_t ev;
        int  c;
        int  e;
        int  gap;
        logic emit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_slow = lvl;
            rst      = rst_v;
            if (rst_v) begin
                e = cyc + 1;
                while (exp_q.size() > 0 && int'(exp_q[$].cyc) >= e) void'(exp_q.pop_back());
                if (e >= 1 && e < HIST && hist_lost[e-1]) begin
                    ev = '0;
                    ev.cyc = 32'(e);
                    exp_q.push_back(ev);
                end
                m_prev = 1'b0; m_armed = 1'b0; m_lost = 1'b0;
                m_period = 8'd0; m_inr = 1'b0; m_ref = e;
                for (int k = e; k < e + LAT && k < HIST; k++) hist_lost[k] = 1'b0;
            end else begin
                c = cyc + LAT;
                ev = '0;
                ev.cyc = 32'(c);
                emit = 1'b0;
                if (lvl && !m_prev) begin
                    ev.tick = 1'b1;
                    emit = 1'b1;
                    if (m_armed) begin
                        gap = c - m_ref;
                        m_period = (gap > 255) ? 8'hFF : 8'(gap);
                        m_inr = (gap >= EXP_PERIOD - TOL) && (gap <= EXP_PERIOD + TOL);
                        ev.vld = 1'b1;
                    end
                    m_armed = 1'b1;
                    m_lost  = 1'b0;
                    m_ref   = c;
                end else if (!lvl && m_prev) begin
                    ev.fall = 1'b1;
                    emit = 1'b1;
                end
                if (!ev.tick && !m_lost && c == m_ref + TIMEOUT) begin
                    m_lost  = 1'b1;
                    m_armed = 1'b0;
                    emit    = 1'b1;
                end
                ev.period = m_period;
                ev.inr    = m_inr;
                ev.lost   = m_lost;
                m_prev    = lvl;
                if (c < HIST) hist_lost[c] = m_lost;
                if (emit) exp_q.push_back(ev);
            end
        end
    endtask

    task automatic checkOutput(input string name);
        n_cmp++;
        if ({tick, tick_fall, period, period_vld, in_range, lost} !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s @%0d: actual tick=%0b fall=%0b period=%0d vld=%0b in_range=%0b lost=%0b, required all 0",
                     name, cyc, tick, tick_fall, period, period_vld, in_range, lost);
        end
    endtask

    task automatic squareWave(input int hi, input int lo, input int reps);
        for (int i = 0; i < reps; i++) begin
            applyStimulus(1'b1, 1'b0, hi);
            applyStimulus(1'b0, 1'b0, lo);
        end
    endtask

    ev_t act;
    ev_t want;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL missed_event: required at cycle %0d (tick=%0b fall=%0b vld=%0b period=%0d lost=%0b), actual none by %0d",
                         exp_q[0].cyc, exp_q[0].tick, exp_q[0].fall, exp_q[0].vld, exp_q[0].period, exp_q[0].lost, cyc);
                void'(exp_q.pop_front());
            end
            if (tick || tick_fall || period_vld || (lost != lost_prev)) begin
                act.cyc = 32'(cyc);
                act.tick = tick;
                act.fall = tick_fall;
                act.vld = period_vld;
                act.period = period;
                act.inr = in_range;
                act.lost = lost;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event @%0d: actual tick=%0b fall=%0b vld=%0b period=%0d lost=%0b, required none",
                             cyc, tick, tick_fall, period_vld, period, lost);
                end else begin
                    want = exp_q.pop_front();
                    if (act != want) begin
                        n_fail++;
                        $display("[TB] FAIL event: actual cyc=%0d tick=%0b fall=%0b vld=%0b period=%0d in_range=%0b lost=%0b, required cyc=%0d tick=%0b fall=%0b vld=%0b period=%0d in_range=%0b lost=%0b",
                                 act.cyc, act.tick, act.fall, act.vld, act.period, act.inr, act.lost,
                                 want.cyc, want.tick, want.fall, want.vld, want.period, want.inr, want.lost);
                    end
                end
            end
            lost_prev = lost;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("reset_state");
        lost_prev = 1'b0;
        mon_en = 1'b1;

        $display("[TB] nominal 8/8");
        applyStimulus(1'b0, 1'b0, 3);
        squareWave(8, 8, 4);

        $display("[TB] out-of-range 10/10 then back to 8/8");
        squareWave(10, 10, 2);
        squareWave(8, 8, 3);

        $display("[TB] loss and recovery");
        applyStimulus(1'b0, 1'b0, 60);
        squareWave(8, 8, 2);

        $display("[TB] rise at timeout boundary");
        squareWave(8, 32, 1);
        squareWave(8, 8, 1);

        $display("[TB] reset mid-period");
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("reset_mid_period");
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b0, 1'b0, 8);
        squareWave(8, 8, 1);

        $display("[TB] high at reset release");
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("reset_high_release");
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 8);
        squareWave(8, 8, 1);

        $display("[TB] randomized half-periods");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, $urandom_range(2, 24));
            applyStimulus(1'b0, 1'b0, $urandom_range(2, 24));
        end

        applyStimulus(1'b0, 1'b0, 60);
        repeat (6) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL leftover_event: required cyc=%0d tick=%0b fall=%0b lost=%0b, actual never presented",
                     exp_q[0].cyc, exp_q[0].tick, exp_q[0].fall, exp_q[0].lost);
            void'(exp_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
